// File: rtl/data_ram_arbiter.sv
// Arbiter sharing the single-port data RAM between the video sprite fetch and the
// CPU load/store port: fixed video priority with a bounded-starvation CPU slot.
module data_ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_rvalid,
    input  logic        cpu_req,
    input  logic        cpu_wren,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [15:0] rdata,
    output logic [15:0] ram_addr_out,
    output logic        ram_wren_out,
    output logic [15:0] ram_data_out,
    input  logic [15:0] ram_data_in,
    output logic [7:0]  cpu_wait
);

    localparam int unsigned SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]  WAIT_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_VID = 2'd1,
        GNT_CPU = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [SW-1:0]            starve_q, starve_d;
    logic [7:0]               wait_q, wait_d;
    logic [15:0]              addr_q, addr_d;
    logic [15:0]              wdata_q, wdata_d;
    logic                     wren_q, wren_d;
    logic                     vack_q, vack_d;
    logic                     cack_q, cack_d;
    // Read-return tags, bit 0 = video read, bit 1 = CPU read; all-zero = no read.
    logic [RD_LAT-1:0][1:0]   tag_q, tag_d;

    // Owner selection for the next cycle.
    always_comb begin
        state_d = IDLE;
        if (vid_req && cpu_req) begin
            if (starve_q == STARVE_MAX) begin
                state_d = GNT_CPU;
            end else begin
                state_d = GNT_VID;
            end
        end else if (vid_req) begin
            state_d = GNT_VID;
        end else if (cpu_req) begin
            state_d = GNT_CPU;
        end else begin
            state_d = IDLE;
        end
    end

    // RAM command and grant pulses registered for the winner.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = 1'b0;
        vack_d  = 1'b0;
        cack_d  = 1'b0;
        case (state_d)
            GNT_VID: begin
                addr_d  = vid_addr;
                wdata_d = cpu_wdata;
                vack_d  = 1'b1;
            end
            GNT_CPU: begin
                addr_d  = cpu_addr;
                wdata_d = cpu_wdata;
                wren_d  = cpu_wren;
                cack_d  = 1'b1;
            end
            default: begin
                addr_d  = addr_q;
                wdata_d = wdata_q;
            end
        endcase
    end

    // Starvation run length and CPU wait counter.
    always_comb begin
        starve_d = starve_q;
        wait_d   = wait_q;
        if (!cpu_req) begin
            starve_d = '0;
        end else if (state_d == GNT_CPU) begin
            starve_d = '0;
        end else if ((state_d == GNT_VID) && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
        if (!cpu_req) begin
            wait_d = 8'd0;
        end else if (cack_q) begin
            wait_d = 8'd0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // Tag of the access on the RAM this cycle enters the return pipeline.
    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = {(state_q == GNT_CPU) && !wren_q, state_q == GNT_VID};
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // State and output registers; reset drops any reads in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            wait_q   <= 8'd0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            wren_q   <= 1'b0;
            vack_q   <= 1'b0;
            cack_q   <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wren_q   <= wren_d;
            vack_q   <= vack_d;
            cack_q   <= cack_d;
            tag_q    <= tag_d;
        end
    end

    assign vid_ack      = vack_q;
    assign cpu_ack      = cack_q;
    assign vid_rvalid   = tag_q[RD_LAT-1][0];
    assign cpu_rvalid   = tag_q[RD_LAT-1][1];
    assign ram_addr_out = addr_q;
    assign ram_wren_out = wren_q;
    assign ram_data_out = wdata_q;
    assign cpu_wait     = wait_q;
    assign rdata        = ram_data_in;

    data_ram_arbiter_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .vid_ack    (vack_q),
        .cpu_ack    (cack_q),
        .vid_rvalid (tag_q[RD_LAT-1][0]),
        .cpu_rvalid (tag_q[RD_LAT-1][1])
    );

endmodule

// Protocol invariants of the arbiter outputs.
module data_ram_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic vid_ack,
    input logic cpu_ack,
    input logic vid_rvalid,
    input logic cpu_rvalid
);

    a_one_ack : assert property (@(posedge clk) disable iff (!rst) !(vid_ack && cpu_ack));
    a_one_rvalid : assert property (@(posedge clk) disable iff (!rst) !(vid_rvalid && cpu_rvalid));

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed self-checking bench for data_ram_arbiter with a 1-cycle-latency RAM model.
module tb_data_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic        vid_rvalid;
    logic        cpu_req;
    logic        cpu_wren;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_rvalid;
    logic [15:0] rdata;
    logic [15:0] ram_addr_out;
    logic        ram_wren_out;
    logic [15:0] ram_data_out;
    logic [15:0] ram_data_in;
    logic [7:0]  cpu_wait;

    int n_cmp;
    int n_err;

    logic [15:0] mem [0:65535];
    logic [15:0] ram_q;

    data_ram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_ack      (vid_ack),
        .vid_rvalid   (vid_rvalid),
        .cpu_req      (cpu_req),
        .cpu_wren     (cpu_wren),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rvalid   (cpu_rvalid),
        .rdata        (rdata),
        .ram_addr_out (ram_addr_out),
        .ram_wren_out (ram_wren_out),
        .ram_data_out (ram_data_out),
        .ram_data_in  (ram_data_in),
        .cpu_wait     (cpu_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM content before any write: addr ^ 0xA5A5
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        ram_q = 16'h0000;
    end

    always @(posedge clk) begin
        if (ram_wren_out) mem[ram_addr_out] <= ram_data_out;
        ram_q <= mem[ram_addr_out];
    end
    assign ram_data_in = ram_q;

    task automatic test_reset();
        rst = 1'b0; vid_req = 1'b0; vid_addr = 16'h0; cpu_req = 1'b0;
        cpu_wren = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if ({vid_ack, cpu_ack, vid_rvalid, cpu_rvalid, ram_wren_out} !== 5'b00000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000", {vid_ack, cpu_ack, vid_rvalid, cpu_rvalid, ram_wren_out});
        end
        n_cmp++;
        if ({ram_addr_out, ram_data_out} !== 32'h0) begin
            n_err++; $display("FAIL reset_addr_data: got %h expected 00000000", {ram_addr_out, ram_data_out});
        end
        n_cmp++;
        if (cpu_wait !== 8'd0) begin
            n_err++; $display("FAIL reset_cpu_wait: got %0d expected 0", cpu_wait);
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        int rv_seen;
        rv_seen = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 16'h0100;
        @(negedge clk);
        n_cmp++;
        if (cpu_ack !== 1'b1 || ram_addr_out !== 16'h0100) begin
            n_err++; $display("FAIL rstmid_ack: got ack=%b addr=%h expected ack=1 addr=0100", cpu_ack, ram_addr_out);
        end
        cpu_req = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({vid_ack, cpu_ack, vid_rvalid, cpu_rvalid, ram_wren_out, ram_addr_out, ram_data_out, cpu_wait} !== 45'h0) begin
            n_err++; $display("FAIL rstmid_zero: got ack=%b%b rv=%b%b wren=%b addr=%h data=%h wait=%0d expected all 0",
                vid_ack, cpu_ack, vid_rvalid, cpu_rvalid, ram_wren_out, ram_addr_out, ram_data_out, cpu_wait);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_rvalid !== 1'b0 || vid_rvalid !== 1'b0) rv_seen++;
        end
        n_cmp++;
        if (rv_seen !== 0) begin
            n_err++; $display("FAIL rstmid_no_rvalid: got %0d rvalid cycles expected 0", rv_seen);
        end
    endtask

    task automatic test_single_video();
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h0A3F;
        @(negedge clk);
        n_cmp++;
        if (ram_addr_out !== 16'h0A3F || vid_ack !== 1'b1 || ram_wren_out !== 1'b0 || cpu_ack !== 1'b0) begin
            n_err++; $display("FAIL vid_grant: got addr=%h vack=%b wren=%b cack=%b expected 0a3f 1 0 0", ram_addr_out, vid_ack, ram_wren_out, cpu_ack);
        end
        vid_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (vid_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || rdata !== 16'hAF9A) begin
            n_err++; $display("FAIL vid_rdata: got vrv=%b crv=%b rdata=%h expected 1 0 af9a", vid_rvalid, cpu_rvalid, rdata);
        end
    endtask

    task automatic test_cpu_write_read();
        @(negedge clk);
        cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
        @(negedge clk);
        n_cmp++;
        if (ram_wren_out !== 1'b1 || cpu_ack !== 1'b1 || ram_addr_out !== 16'h0020 || ram_data_out !== 16'h1234) begin
            n_err++; $display("FAIL cpu_write: got wren=%b ack=%b addr=%h data=%h expected 1 1 0020 1234", ram_wren_out, cpu_ack, ram_addr_out, ram_data_out);
        end
        cpu_wren = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ram_wren_out !== 1'b0 || cpu_ack !== 1'b1 || cpu_rvalid !== 1'b0) begin
            n_err++; $display("FAIL cpu_read_grant: got wren=%b ack=%b crv=%b expected 0 1 0", ram_wren_out, cpu_ack, cpu_rvalid);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cpu_rvalid !== 1'b1 || vid_rvalid !== 1'b0 || rdata !== 16'h1234 || ram_wren_out !== 1'b0) begin
            n_err++; $display("FAIL cpu_readback: got crv=%b vrv=%b rdata=%h wren=%b expected 1 0 1234 0", cpu_rvalid, vid_rvalid, rdata, ram_wren_out);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0]  exp_g;
        logic [1:0]  prev_g;
        logic [15:0] exp_d;
        logic [7:0]  peak;
        peak = 8'd0; prev_g = 2'b00;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h0300;
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 16'h0040; cpu_wdata = 16'h0000;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_d = (prev_g == 2'b10) ? 16'hA5E5 : 16'hA6A5;
                n_cmp++;
                if ({cpu_rvalid, vid_rvalid} !== prev_g || rdata !== exp_d) begin
                    n_err++; $display("FAIL sim_rvalid[%0d]: got rv=%b rdata=%h expected rv=%b rdata=%h", i - 1, {cpu_rvalid, vid_rvalid}, rdata, prev_g, exp_d);
                end
            end
            if (i < 20) begin
                exp_g = (i == 8 || i == 17) ? 2'b10 : 2'b01;
                n_cmp++;
                if ({cpu_ack, vid_ack} !== exp_g) begin
                    n_err++; $display("FAIL sim_grant[%0d]: got {cack,vack}=%b expected %b", i, {cpu_ack, vid_ack}, exp_g);
                end
                if (cpu_wait > peak) peak = cpu_wait;
                prev_g = exp_g;
            end
            if (i == 19) begin
                vid_req = 1'b0; cpu_req = 1'b0;
            end
        end
        n_cmp++;
        if (peak !== 8'd9) begin
            n_err++; $display("FAIL sim_wait_peak: got %0d expected 9", peak);
        end
    endtask

    task automatic test_back_to_back();
        int          ack_ok;
        int          rv_ok;
        logic [15:0] a;
        logic [15:0] exp_d;
        ack_ok = 0; rv_ok = 0;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h0000;
        for (int j = 0; j < 65; j++) begin
            @(negedge clk);
            if (j < 64 && vid_ack === 1'b1 && cpu_ack === 1'b0 && ram_addr_out === 16'(j)) ack_ok++;
            if (j > 0) begin
                a = 16'(j - 1);
                exp_d = (a == 16'h0020) ? 16'h1234 : (a ^ 16'hA5A5);
                if (vid_rvalid === 1'b1 && cpu_rvalid === 1'b0 && rdata === exp_d) rv_ok++;
            end
            if (j < 63) vid_addr = 16'(j + 1);
            else vid_req = 1'b0;
        end
        n_cmp++;
        if (ack_ok !== 64) begin
            n_err++; $display("FAIL b2b_acks: got %0d in-order acks expected 64", ack_ok);
        end
        n_cmp++;
        if (rv_ok !== 64) begin
            n_err++; $display("FAIL b2b_rvalids: got %0d in-order rvalids expected 64", rv_ok);
        end
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (vid_ack !== 1'b0 || cpu_ack !== 1'b0 || ram_wren_out !== 1'b0 || cpu_wait !== 8'd0 || ram_addr_out !== 16'h003F) begin
                bad++;
                $display("FAIL idle[%0d]: got vack=%b cack=%b wren=%b wait=%0d addr=%h expected 0 0 0 0 003f",
                    i, vid_ack, cpu_ack, ram_wren_out, cpu_wait, ram_addr_out);
            end
        end
        n_cmp++;
        if (bad !== 0) n_err++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_reset_mid();
        test_single_video();
        test_cpu_write_read();
        test_simultaneous();
        test_back_to_back();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
